// File: rtl/addr_decoder_split_pkg.sv
// Shared bus definitions: state encoding, default sizing and the clog2 helper
// used by the address decoder, the arbiter and the read/response muxes.
package bus_pkg;

  localparam int DEF_NUM_SLAVES        = 3;
  localparam int DEF_DEVICE_ADDR_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    CONNECT = 3'd2,
    WAIT    = 3'd3,
    SPLIT   = 3'd4
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/addr_decoder_split_onehot.sv
// Enable-gated one-hot slave decoder; a select beyond the last slave yields
// an all-zero vector.
module addr_dec_onehot
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int SEL_WIDTH  = 2
) (
  input  logic [SEL_WIDTH-1:0]  sel,
  input  logic                  en,
  output logic [NUM_SLAVES-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (en && (sel == SEL_WIDTH'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/addr_decoder_split.sv
// Split-aware serial address decoder, one per master port.
// Optional feature: define DECODE_ERR_EN to add the decode_err pulse output.
module addr_decoder_split
  import bus_pkg::*;
#(
  parameter int  NUM_SLAVES        = DEF_NUM_SLAVES,
  parameter int  DEVICE_ADDR_WIDTH = DEF_DEVICE_ADDR_WIDTH,
  localparam int SEL_WIDTH         = (clog2(NUM_SLAVES) < 1) ? 1 : clog2(NUM_SLAVES)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mwdata,
  input  logic                  mvalid,
  input  logic                  ssplit,
  input  logic                  split_grant,
  output logic [NUM_SLAVES-1:0] mvalid_s,
  output logic [SEL_WIDTH-1:0]  ssel,
  output logic                  ack,
`ifdef DECODE_ERR_EN
  output logic                  decode_err,
`endif
  output logic                  split_active
);

  localparam int CNT_W = clog2(DEVICE_ADDR_WIDTH);
  localparam logic [DEVICE_ADDR_WIDTH:0] NS_EXT = (DEVICE_ADDR_WIDTH+1)'(NUM_SLAVES);

  state_t                       r_state;
  logic [DEVICE_ADDR_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]             r_cnt;
  logic [SEL_WIDTH-1:0]         r_ssel;
  logic [SEL_WIDTH-1:0]         r_splitSel;
  logic                         r_slaveEn;

  logic [DEVICE_ADDR_WIDTH-1:0] w_addrNext;
  logic                         w_lastBit;
  logic                         w_nextValid;
  logic                         w_valid;

  // Address as it will look once the bit on mwdata this cycle is stored.
  always_comb begin
    w_addrNext        = r_addr;
    w_addrNext[r_cnt] = mwdata;
  end

  assign w_lastBit   = (r_cnt == CNT_W'(DEVICE_ADDR_WIDTH - 1));
  assign w_nextValid = ({1'b0, w_addrNext} < NS_EXT);
  assign w_valid     = ({1'b0, r_addr} < NS_EXT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_ssel     <= '0;
      r_splitSel <= '0;
      r_slaveEn  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_slaveEn <= 1'b0;
          if (mvalid) begin
            r_addr  <= {{(DEVICE_ADDR_WIDTH-1){1'b0}}, mwdata};
            r_cnt   <= CNT_W'(1);
            r_state <= ADDR;
          end
        end
        ADDR: begin
          if (!mvalid) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_addr <= w_addrNext;
            if (w_lastBit) begin
              r_cnt     <= '0;
              r_ssel    <= w_addrNext[SEL_WIDTH-1:0];
              r_slaveEn <= w_nextValid;
              r_state   <= CONNECT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        CONNECT: begin
          if (!w_valid) begin
            r_slaveEn <= 1'b0;
            r_state   <= IDLE;
          end else if (mvalid) begin
            r_state <= WAIT;
          end
        end
        // A split request outranks the master dropping valid in the same cycle.
        WAIT: begin
          if (ssplit) begin
            r_splitSel <= r_ssel;
            r_slaveEn  <= 1'b0;
            r_state    <= SPLIT;
          end else if (!mvalid) begin
            r_slaveEn <= 1'b0;
            r_state   <= IDLE;
          end
        end
        SPLIT: begin
          if (split_grant) begin
            r_ssel    <= r_splitSel;
            r_slaveEn <= 1'b1;
            r_state   <= CONNECT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ssel         = r_ssel;
  assign ack          = (r_state == CONNECT) && w_valid;
  assign split_active = (r_state == SPLIT);
`ifdef DECODE_ERR_EN
  assign decode_err   = (r_state == CONNECT) && !w_valid;
`endif

  addr_dec_onehot #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_onehot (
    .sel    (r_ssel),
    .en     (mvalid & r_slaveEn),
    .onehot (mvalid_s)
  );

endmodule

// File: doc/addr_decoder_split.md
Name: addr_decoder_split

Overview:
- Parametrised, split-aware successor to the bus address decoder; one instance per master port of the system bus.
- Receives the slave device address serially, LSB first, on the master write-data line.
- Checks the address against NUM_SLAVES, acks the master, then routes mvalid to one of NUM_SLAVES slaves and drives the slave select for the read/response muxes.
- Handles slave SPLIT transactions: parks the connection and resumes it on the arbiter's split_grant without re-sending the address.

Parameters:
- NUM_SLAVES, 3, number of attached slaves (2..16).
- DEVICE_ADDR_WIDTH, 4, serial device-address bits (>=2, 2^DEVICE_ADDR_WIDTH >= NUM_SLAVES).
- SEL_WIDTH, max(1,clog2(NUM_SLAVES)), slave select width (derived localparam, not overridable).

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- mwdata  in  1  serial master write-data line; carries address bits during address phase.
- mvalid  in  1  master valid.
- ssplit  in  1  split request from currently selected slave (already muxed).
- split_grant  in  1  arbiter pulse ending a split.
- mvalid_s  out  NUM_SLAVES  per-slave valid, one-hot or zero.
- ssel  out  SEL_WIDTH  registered slave select to muxes.
- ack  out  1  address acknowledge to master.
- split_active  out  1  high while connection is parked in SPLIT.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; ssel=0, slave_en=0, addr register=0, bit counter=0, saved split slave=0.
  - All outputs 0.
- States: IDLE, ADDR, CONNECT, WAIT, SPLIT.
- IDLE:
  - mvalid=1: capture mwdata into addr[0], counter<=1, go ADDR.
  - Otherwise hold; slave_en<=0.
- ADDR:
  - Each cycle: addr[counter]<=mwdata, counter++.
  - At counter==DEVICE_ADDR_WIDTH-1 (last bit captured): go CONNECT; ssel<=addr[SEL_WIDTH-1:0] using the just-captured bit; slave_en<=valid.
  - Address phase is DEVICE_ADDR_WIDTH cycles including the IDLE capture cycle.
  - mvalid=0 during ADDR: abort to IDLE, counter<=0, partial address discarded, no ack.
- CONNECT:
  - valid = full DEVICE_ADDR_WIDTH-bit address < NUM_SLAVES.
  - ack = (state==CONNECT) & valid, combinational.
  - Invalid address: ack=0, slave_en=0, next state IDLE.
  - Valid address: mvalid=1 goes WAIT, else stay CONNECT (ack held high).
- WAIT:
  - mvalid_s[i] = mvalid & slave_en & (ssel==i).
  - mvalid=0: go IDLE, slave_en<=0.
  - ssplit=1: go SPLIT, save ssel, slave_en<=0.
  - ssplit wins over mvalid=0 in the same cycle.
- SPLIT:
  - split_active=1; mvalid_s all 0; mvalid and mwdata ignored; ssel held.
  - split_grant=1: ssel<=saved slave, slave_en<=1, go CONNECT (ack reasserts next cycle, no address re-send).
  - split_grant outside SPLIT is ignored.
- Reset in any state, including mid-ADDR or mid-SPLIT: immediate return to reset values; saved split context is lost.
- mvalid_s is combinational from registered state, so it has zero added latency relative to mvalid.

Optional Feature:
- Macro: DECODE_ERR_EN.
- Defined: adds output decode_err (1 bit, reset 0). It is a one-cycle pulse in CONNECT when the address is invalid; same cycle as the would-be ack; ack stays 0.
- Undefined: port absent; an invalid address silently returns to IDLE with no ack.

Decomposition:
- Shared package bus_pkg holds:
  - state encoding localparams (IDLE=0, ADDR=1, CONNECT=2, WAIT=3, SPLIT=4, 3-bit);
  - the clog2 helper function;
  - default NUM_SLAVES and DEVICE_ADDR_WIDTH, shared with arbiter and muxes.
- One natural sub-module: addr_dec_onehot.
  - Parametrised replacement for the fixed 3-output decoder.
  - Inputs: sel (SEL_WIDTH), en (1); output: one-hot of NUM_SLAVES.
  - sel >= NUM_SLAVES gives all zeros.

Test Plan (NUM_SLAVES=3, DEVICE_ADDR_WIDTH=4 unless noted):
- Normal transfer: mvalid=1, mwdata bits 0,1,0,0 over 4 cycles (address 2) -> CONNECT; ack=1; ssel=2; with mvalid held, mvalid_s=3'b100 in WAIT; mvalid low -> IDLE, mvalid_s=0.
- Invalid address: bits 1,1,0,0 (address 3) -> ack stays 0; mvalid_s stays 0; IDLE next cycle. With DECODE_ERR_EN, decode_err pulses exactly one cycle.
- Abort: mvalid drops after 2 address bits -> IDLE. A fresh address 1 (1,0,0,0) then gives ssel=1 and ack, with no contamination from the partial bits.
- Split/resume: address 1 connected; ssplit=1 in WAIT -> split_active=1, mvalid_s=0. Toggle mvalid and mwdata for 5 cycles -> no effect. split_grant -> CONNECT, ack=1, ssel=1, no address bits consumed.
- Simultaneous events: in WAIT, ssplit=1 and mvalid=0 in the same cycle -> SPLIT (not IDLE). Async rstn pulse mid-ADDR and mid-SPLIT -> all outputs 0 immediately, state IDLE.
- Scaling: NUM_SLAVES=5, DEVICE_ADDR_WIDTH=3 -> address 4 gives mvalid_s=5'b10000 and ssel=3'd4; address 5 gives no ack.
